// File: rtl/fetch_branch_predictor_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
package bp_pkg;

    localparam logic [1:0] BP_SNT       = 2'b00;
    localparam logic [1:0] BP_WNT       = 2'b01;
    localparam logic [1:0] BP_WT        = 2'b10;
    localparam logic [1:0] BP_ST        = 2'b11;
    localparam logic [1:0] BP_ALLOC_CTR = BP_WT;

    // Tag is sized for the smallest table; unused upper bits stay zero.
    localparam int BP_TAG_W = 30;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [31:0]         target;
        logic [1:0]          ctr;
    } bp_entry_t;

    // Tag of a word address (pc[31:2]) for a table with idx_w index bits.
    function automatic logic [BP_TAG_W-1:0] bp_tag(input logic [29:0] pc_w, input int idx_w);
        return pc_w >> idx_w;
    endfunction

endpackage

// File: rtl/fetch_branch_predictor_if.sv
// Fetch lookup, execute resolution and memory-stage redirect signals of the predictor.
interface fetch_branch_predictor_if;

    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;

    logic        upd_valid_e;
    logic [31:0] upd_pc_e;
    logic        upd_taken_e;
    logic [31:0] upd_target_e;
    logic        upd_pred_taken_e;
    logic [31:0] upd_pred_target_e;

    logic        mispredict_m;
    logic [31:0] redirect_pc_m;

    modport master (
        output pc_f, upd_valid_e, upd_pc_e, upd_taken_e, upd_target_e,
               upd_pred_taken_e, upd_pred_target_e,
        input  pred_taken_f, pred_target_f, mispredict_m, redirect_pc_m
    );

    modport slave (
        input  pc_f, upd_valid_e, upd_pc_e, upd_taken_e, upd_target_e,
               upd_pred_taken_e, upd_pred_target_e,
        output pred_taken_f, pred_target_f, mispredict_m, redirect_pc_m
    );

endinterface

// File: rtl/fetch_branch_predictor_sat_counter.sv
// 2-bit saturating counter next-state logic for the BTB update path.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != BP_ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != BP_SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/fetch_branch_predictor.sv
// Direct-mapped BTB predictor with registered mispredict/redirect.
// Optional statistics counters are enabled by defining BP_STATS_EN.
module fetch_branch_predictor
    import bp_pkg::*;
#(
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] INIT_CTR = 2'b01
) (
    input  logic clk,
    input  logic rst,
`ifdef BP_STATS_EN
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts,
`endif
    fetch_branch_predictor_if.slave bp
);

    localparam int IDX = $clog2(ENTRIES);

    bp_entry_t   btb_q [ENTRIES];
    logic        mispredict_q;
    logic [31:0] redirect_pc_q;

    logic [IDX-1:0] idx_f;
    bp_entry_t      ent_f;
    logic           hit_f;

    logic [IDX-1:0] upd_idx;
    bp_entry_t      upd_ent;
    logic           upd_hit;
    logic [1:0]     ctr_next;
    logic [31:0]    actual_pc;
    logic [31:0]    predicted_pc;
    logic           mispredict_d;
    logic [31:0]    redirect_pc_d;

    always_comb begin
        idx_f = bp.pc_f[IDX+1:2];
        ent_f = btb_q[idx_f];
        hit_f = ent_f.valid && (ent_f.tag == bp_tag(bp.pc_f[31:2], IDX));
        bp.pred_taken_f  = hit_f && ent_f.ctr[1];
        bp.pred_target_f = bp.pred_taken_f ? ent_f.target : bp.pc_f + 32'd4;
    end

    always_comb begin
        upd_idx = bp.upd_pc_e[IDX+1:2];
        upd_ent = btb_q[upd_idx];
        upd_hit = upd_ent.valid && (upd_ent.tag == bp_tag(bp.upd_pc_e[31:2], IDX));

        actual_pc     = bp.upd_taken_e      ? bp.upd_target_e      : bp.upd_pc_e + 32'd4;
        predicted_pc  = bp.upd_pred_taken_e ? bp.upd_pred_target_e : bp.upd_pc_e + 32'd4;
        mispredict_d  = bp.upd_valid_e && (actual_pc != predicted_pc);
        redirect_pc_d = mispredict_d ? actual_pc : redirect_pc_q;
    end

    bp_sat_counter u_sat_counter (
        .ctr_i   (upd_ent.ctr),
        .taken_i (bp.upd_taken_e),
        .ctr_o   (ctr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: INIT_CTR};
            end
        end else if (bp.upd_valid_e) begin
            if (upd_hit) begin
                btb_q[upd_idx].ctr <= ctr_next;
                if (bp.upd_taken_e) btb_q[upd_idx].target <= bp.upd_target_e;
            end else if (bp.upd_taken_e) begin
                btb_q[upd_idx] <= '{valid:  1'b1,
                                    tag:    bp_tag(bp.upd_pc_e[31:2], IDX),
                                    target: bp.upd_target_e,
                                    ctr:    BP_ALLOC_CTR};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign bp.mispredict_m  = mispredict_q;
    assign bp.redirect_pc_m = redirect_pc_q;

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispredicts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (bp.upd_valid_e) stat_branches_q    <= stat_branches_q + 32'd1;
            if (mispredict_d)   stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_fetch_branch_predictor.sv
// Randomized and directed checks of fetch_branch_predictor against a table-level reference model.
module tb_fetch_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int IDX     = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_branch_predictor_if bp ();

`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    fetch_branch_predictor #(
        .ENTRIES  (ENTRIES),
        .INIT_CTR (2'b01)
    ) dut (
        .clk              (clk),
        .rst              (rst),
`ifdef BP_STATS_EN
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
`endif
        .bp               (bp)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain per-entry arrays, counters as integers 0..3.
    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    logic        exp_mis;
    logic [31:0] exp_redir;
    logic [31:0] exp_br;
    logic [31:0] exp_mp;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int m_index(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic m_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        int i;
        i  = m_index(pc);
        tk = m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2);
        tg = tk ? m_target[i] : pc + 32'd4;
    endtask

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        exp_mis   = 1'b0;
        exp_redir = '0;
        exp_br    = '0;
        exp_mp    = '0;
    endtask

    // One clock: drive inputs, check lookup before the edge, then registered outputs after it.
    task automatic cycle(input logic r, input logic [31:0] pc,
                         input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                         input logic upt, input logic [31:0] uptg);
        logic        etk;
        logic [31:0] etg, act, prd;
        int          i;
        rst                  = r;
        bp.pc_f              = pc;
        bp.upd_valid_e       = uv;
        bp.upd_pc_e          = upc;
        bp.upd_taken_e       = ut;
        bp.upd_target_e      = utg;
        bp.upd_pred_taken_e  = upt;
        bp.upd_pred_target_e = uptg;
        #1;
        m_lookup(pc, etk, etg);
        check_val("pred_taken_f", {31'd0, bp.pred_taken_f}, {31'd0, etk});
        check_val("pred_target_f", bp.pred_target_f, etg);
        @(posedge clk);
        if (r) begin
            m_reset();
        end else begin
            act     = ut  ? utg  : upc + 32'd4;
            prd     = upt ? uptg : upc + 32'd4;
            exp_mis = uv && (act != prd);
            if (exp_mis) exp_redir = act;
            if (uv) begin
                exp_br = exp_br + 32'd1;
                if (exp_mis) exp_mp = exp_mp + 32'd1;
                i = m_index(upc);
                if (m_valid[i] && m_tag[i] == m_tagof(upc)) begin
                    if (ut) begin
                        m_ctr[i]    = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                        m_target[i] = utg;
                    end else begin
                        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                    end
                end else if (ut) begin
                    m_valid[i]  = 1'b1;
                    m_tag[i]    = m_tagof(upc);
                    m_target[i] = utg;
                    m_ctr[i]    = 2;
                end
            end
        end
        #1;
        check_val("mispredict_m", {31'd0, bp.mispredict_m}, {31'd0, exp_mis});
        check_val("redirect_pc_m", bp.redirect_pc_m, exp_redir);
`ifdef BP_STATS_EN
        check_val("stat_branches", stat_branches, exp_br);
        check_val("stat_mispredicts", stat_mispredicts, exp_mp);
`endif
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        bp.pc_f        = pc;
        bp.upd_valid_e = 1'b0;
        #1;
        check_val({tag, "_taken"}, {31'd0, bp.pred_taken_f}, {31'd0, tk});
        check_val({tag, "_target"}, bp.pred_target_f, tg);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        logic        pt;
        logic [31:0] ptg;
        m_lookup(pc, pt, ptg);
        cycle(1'b0, pc, 1'b1, pc, tk, tg, pt, ptg);
    endtask

    function automatic logic [31:0] rnd_pc();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
        return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    initial begin
        logic        pt;
        logic [31:0] ptg, pc, upc, utg;
        rst                  = 1'b1;
        bp.pc_f              = '0;
        bp.upd_valid_e       = 1'b0;
        bp.upd_pc_e          = '0;
        bp.upd_taken_e       = 1'b0;
        bp.upd_target_e      = '0;
        bp.upd_pred_taken_e  = 1'b0;
        bp.upd_pred_target_e = '0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();

        // Reset release and first lookup
        cycle(1'b0, 32'h100, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        look("s1", 32'h100, 1'b0, 32'h104);
        check_val("s1_mis", {31'd0, bp.mispredict_m}, 32'd0);

        // Miss-taken allocation with mispredict
        cycle(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        check_val("s2_mis", {31'd0, bp.mispredict_m}, 32'd1);
        check_val("s2_redir", bp.redirect_pc_m, 32'h200);
        look("s2", 32'h100, 1'b1, 32'h200);

        // Aliasing tag at the same index
        look("s3_alias", 32'h140, 1'b0, 32'h144);
        cycle(1'b0, 32'h140, 1'b1, 32'h140, 1'b0, 32'h0, 1'b0, 32'h144);
        look("s3_keep", 32'h100, 1'b1, 32'h200);

        // Saturation both ways: 10 -> 11 -> 01 -> 00 -> 01 -> 10 -> 11 -> 01
        repeat (3) upd(32'h100, 1'b1, 32'h200);
        repeat (2) upd(32'h100, 1'b0, 32'h0);
        look("s4_wnt", 32'h100, 1'b0, 32'h104);
        repeat (3) upd(32'h100, 1'b0, 32'h0);
        look("s4_snt", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h200);
        look("s4_up1", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h200);
        look("s4_up2", 32'h100, 1'b1, 32'h200);
        repeat (3) upd(32'h100, 1'b1, 32'h200);
        repeat (2) upd(32'h100, 1'b0, 32'h0);
        look("s4_top", 32'h100, 1'b0, 32'h104);
        repeat (2) upd(32'h100, 1'b1, 32'h200);

        // Correct prediction, then same-cycle lookup/update on a fresh index
        cycle(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        check_val("s5_nomis", {31'd0, bp.mispredict_m}, 32'd0);
        cycle(1'b0, 32'h114, 1'b1, 32'h114, 1'b1, 32'h300, 1'b0, 32'h118);
        look("s5_after", 32'h114, 1'b1, 32'h300);

        // Fall-through PC wraps to zero
        cycle(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h40);
        check_val("wrap_mis", {31'd0, bp.mispredict_m}, 32'd1);
        check_val("wrap_redir", bp.redirect_pc_m, 32'h0);
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // Reset beats a mispredicting update
        cycle(1'b1, 32'h100, 1'b1, 32'h180, 1'b1, 32'h500, 1'b0, 32'h184);
        check_val("s6_mis", {31'd0, bp.mispredict_m}, 32'd0);
        check_val("s6_redir", bp.redirect_pc_m, 32'd0);
        look("s6_a", 32'h100, 1'b0, 32'h104);
        look("s6_b", 32'h114, 1'b0, 32'h118);
`ifdef BP_STATS_EN
        check_val("s6_stat_br", stat_branches, 32'd0);
        check_val("s6_stat_mp", stat_mispredicts, 32'd0);
`endif
        cycle(1'b0, 32'h100, 1'b0, '0, 1'b0, '0, 1'b0, '0);

        // Random traffic over a small PC pool so hits and aliasing are frequent
        for (int n = 0; n < 2000; n++) begin
            pc  = rnd_pc();
            upc = rnd_pc();
            utg = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) utg = upc + 32'd4;
            m_lookup(upc, pt, ptg);
            if ($urandom_range(0, 7) == 0) begin
                pt  = 1'($urandom_range(0, 1));
                ptg = $urandom() & 32'hFFFF_FFFC;
            end
            cycle(($urandom_range(0, 99) == 0), pc, 1'($urandom_range(0, 3) != 0),
                  upc, 1'($urandom_range(0, 1)), utg, pt, ptg);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
